// File: rtl/pts_tx_pkg.sv
// Shared types and frame sizing for the parallel-to-serial transmit sequencer.
// Build option: define PTS_TX_PARITY_EN to add an even-parity bit to each frame.
package pts_tx_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} tx_state_t;

`ifdef PTS_TX_PARITY_EN
  localparam int PARITY_BITS = 1;
`else
  localparam int PARITY_BITS = 0;
`endif

  // start + data + optional parity + stop
  function automatic int frame_bits(input int data_bits);
    return data_bits + 2 + PARITY_BITS;
  endfunction

endpackage

// File: rtl/pts_tx_ctrl_bit_period_timer.sv
// Wrap counter: holds 0 when cleared, then counts 1..rollover_val and wraps
// back to 1, so the count never exceeds rollover_val and cannot overflow.
module bit_period_timer #(
  parameter int MAX_VAL = 4,
  localparam int W = $clog2(MAX_VAL + 1)
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         clear,
  input  logic         enable,
  input  logic [W-1:0] rollover_val,
  output logic         rollover_flag
);

  logic [W-1:0] r_count;

  // count 1..rollover_val, clear wins over enable
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)                       r_count <= '0;
    else if (clear)                   r_count <= '0;
    else if (enable) begin
      if (r_count == rollover_val)    r_count <= W'(1);
      else                            r_count <= r_count + W'(1);
    end
  end

  assign rollover_flag = (r_count == rollover_val);

endmodule

// File: rtl/pts_tx_ctrl.sv
// UART-style transmit sequencer driving an LSB-first, one-fill shift register.
// Frame image {stop=1, [parity], data, start=0}; bit period CLKS_PER_BIT clocks.
// Build option: PTS_TX_PARITY_EN adds an even-parity bit above the data.
module pts_tx_ctrl
  import pts_tx_pkg::*;
#(
  parameter int  DATA_BITS    = 8,
  parameter int  CLKS_PER_BIT = 4,
  localparam int FRAME_BITS   = frame_bits(DATA_BITS)
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic [DATA_BITS-1:0]  tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [FRAME_BITS-1:0] sr_parallel_out,
  output logic                  sr_load_enable,
  output logic                  sr_shift_enable,
  output logic                  tx_busy,
  output logic                  frame_done
);

  localparam int TW = $clog2(CLKS_PER_BIT + 1);
  localparam int BW = $clog2(FRAME_BITS + 1);

  tx_state_t             r_state;
  logic [FRAME_BITS-1:0] r_frame;
  logic [FRAME_BITS-1:0] w_frame_img;
  logic                  w_tick;
  logic                  w_bit_last;
  logic                  w_shift;
  logic                  w_active;
  logic                  w_idle_or_done;

`ifdef PTS_TX_PARITY_EN
  assign w_frame_img = {1'b1, ^tx_data, tx_data, 1'b0};
`else
  assign w_frame_img = {1'b1, tx_data, 1'b0};
`endif

  assign w_active       = (r_state == LOAD) || (r_state == SHIFT);
  assign w_idle_or_done = (r_state == IDLE) || (r_state == DONE);
  assign w_shift        = (r_state == SHIFT) && w_tick;

  // Bit timer: steps 0->1 in LOAD so the first SHIFT cycle sees 1 and the
  // first pulse lands CLKS_PER_BIT cycles after the load.
  bit_period_timer #(.MAX_VAL(CLKS_PER_BIT)) u_bit_timer (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (w_idle_or_done),
    .enable       (w_active),
    .rollover_val (TW'(CLKS_PER_BIT)),
    .rollover_flag(w_tick)
  );

  // Bit counter: also steps once in LOAD, so it holds the 1-based index of the
  // bit on the line; its flag during a shift pulse marks the final (stop) bit.
  bit_period_timer #(.MAX_VAL(FRAME_BITS)) u_bit_cnt (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (w_idle_or_done),
    .enable       ((r_state == LOAD) || w_shift),
    .rollover_val (BW'(FRAME_BITS)),
    .rollover_flag(w_bit_last)
  );

  // Frame sequencing and word capture at the accept edge
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= IDLE;
      r_frame <= '1;
    end else begin
      case (r_state)
        IDLE:  if (tx_valid) begin
                 r_frame <= w_frame_img;
                 r_state <= LOAD;
               end
        LOAD:  r_state <= SHIFT;
        SHIFT: if (w_shift && w_bit_last) r_state <= DONE;
        DONE:  r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign tx_ready        = (r_state == IDLE);
  assign tx_busy         = (r_state != IDLE);
  assign sr_load_enable  = (r_state == LOAD);
  assign sr_shift_enable = w_shift;
  assign frame_done      = (r_state == DONE);
  assign sr_parallel_out = r_frame;

endmodule

// File: tb/tb_pts_tx_ctrl.sv
// Bench: two controllers (CLKS_PER_BIT 4 and 1) checked every cycle against a
// cycle-offset model of the frame, plus directed frames with literal timings.
module tb_pts_tx_ctrl;
  import pts_tx_pkg::*;

  localparam int DB = 8;
  localparam int FB = frame_bits(DB);
`ifdef PTS_TX_PARITY_EN
  localparam logic [FB-1:0] ONES   = 11'h7FF;
  localparam logic [FB-1:0] F_A5   = 11'b1_0_10100101_0;
  localparam logic [FB-1:0] F_3C   = 11'b1_0_00111100_0;
  localparam logic [FB-1:0] F_FF   = 11'b1_0_11111111_0;
  localparam logic [FB-1:0] F_81   = 11'b1_0_10000001_0;
  localparam int LAST4 = 45, DONE4 = 46, RDY4 = 47, NEXTLD = 48;
  localparam int LAST1 = 12, DONE1 = 13;
`else
  localparam logic [FB-1:0] ONES   = 10'h3FF;
  localparam logic [FB-1:0] F_A5   = 10'b1_10100101_0;
  localparam logic [FB-1:0] F_3C   = 10'b1_00111100_0;
  localparam logic [FB-1:0] F_FF   = 10'b1_11111111_0;
  localparam logic [FB-1:0] F_81   = 10'b1_10000001_0;
  localparam int LAST4 = 41, DONE4 = 42, RDY4 = 43, NEXTLD = 44;
  localparam int LAST1 = 11, DONE1 = 12;
`endif

  logic clk = 1'b0;
  logic n_rst;
  logic [1:0] vld = 2'b00;
  logic [DB-1:0] dat [2] = '{default: '0};
  logic [1:0] rdy, ld, sh, busy, dn;
  logic [FB-1:0] par [2];

  int total = 0, bad = 0;
  int cpb [2] = '{4, 1};

  always #5 clk = ~clk;

  pts_tx_ctrl #(.DATA_BITS(DB), .CLKS_PER_BIT(4)) u0 (
    .clk(clk), .n_rst(n_rst), .tx_data(dat[0]), .tx_valid(vld[0]), .tx_ready(rdy[0]),
    .sr_parallel_out(par[0]), .sr_load_enable(ld[0]), .sr_shift_enable(sh[0]),
    .tx_busy(busy[0]), .frame_done(dn[0]));

  pts_tx_ctrl #(.DATA_BITS(DB), .CLKS_PER_BIT(1)) u1 (
    .clk(clk), .n_rst(n_rst), .tx_data(dat[1]), .tx_valid(vld[1]), .tx_ready(rdy[1]),
    .sr_parallel_out(par[1]), .sr_load_enable(ld[1]), .sr_shift_enable(sh[1]),
    .tx_busy(busy[1]), .frame_done(dn[1]));

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [FB-1:0] img(input logic [DB-1:0] d);
`ifdef PTS_TX_PARITY_EN
    return {1'b1, ^d, d, 1'b0};
`else
    return {1'b1, d, 1'b0};
`endif
  endfunction

  // Model: a frame is "k cycles since its accept edge"; busy while k <= 2+FB*cpb
  bit            m_busy [2] = '{0, 0};
  int            m_k    [2] = '{0, 0};
  logic [FB-1:0] m_frame[2] = '{default: '1};

  always @(posedge clk or negedge n_rst) begin
    for (int d = 0; d < 2; d++) begin
      if (!n_rst) begin
        m_busy[d] = 0; m_k[d] = 0; m_frame[d] = '1;
      end else if (m_busy[d]) begin
        m_k[d]++;
        if (m_k[d] > 2 + FB * cpb[d]) begin m_busy[d] = 0; m_k[d] = 0; end
      end else if (vld[d]) begin
        m_busy[d] = 1; m_k[d] = 1; m_frame[d] = img(dat[d]);
      end
    end
  end

  // Attached shift register (LSB-first, one-fill) driven by the DUT enables
  logic          s_ld [2] = '{0, 0};
  logic          s_sh [2] = '{0, 0};
  logic [FB-1:0] s_par[2] = '{default: '1};
  logic [FB-1:0] bsr  [2] = '{default: '1};

  always @(posedge clk or negedge n_rst) begin
    for (int d = 0; d < 2; d++) begin
      if (!n_rst)        bsr[d] = '1;
      else if (s_ld[d])  bsr[d] = s_par[d];
      else if (s_sh[d])  bsr[d] = {1'b1, bsr[d][FB-1:1]};
    end
  end

  // Per-cycle compare, sampled just after the falling edge
  always begin
    int k, c, bi;
    bit b, e_ld, e_sh, e_dn;
    logic e_ser;
    @(negedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      k = m_k[d]; b = m_busy[d]; c = cpb[d];
      e_ld = b && (k == 1);
      e_sh = b && (k >= 1 + c) && (k <= 1 + FB * c) && ((k - 1) % c == 0);
      e_dn = b && (k == 2 + FB * c);
      bi = (k - 2) / c;
      e_ser = (b && k >= 2 && bi < FB) ? m_frame[d][bi] : 1'b1;
      chk($sformatf("d%0d k%0d ready", d, k), rdy[d],  !b);
      chk($sformatf("d%0d k%0d busy", d, k),  busy[d], b);
      chk($sformatf("d%0d k%0d load", d, k),  ld[d],   e_ld);
      chk($sformatf("d%0d k%0d shift", d, k), sh[d],   e_sh);
      chk($sformatf("d%0d k%0d done", d, k),  dn[d],   e_dn);
      chk($sformatf("d%0d k%0d par", d, k),   par[d],  m_frame[d]);
      chk($sformatf("d%0d k%0d serial", d, k), bsr[d][0], e_ser);
      s_ld[d] = ld[d]; s_sh[d] = sh[d]; s_par[d] = par[d];
    end
  end

  // Directed-test observation
  int ld_q[$], sh_q[$], dn_q[$];
  int rdy_first;
  logic [FB-1:0] par1, par_mid, ser_v;

  task automatic accept(input int d, input logic [DB-1:0] v);
    @(negedge clk);
    vld[d] = 1'b1; dat[d] = v;
    for (int i = 0; i < 200 && !rdy[d]; i++) @(negedge clk);
    if (!rdy[d]) chk("accept timeout", 0, 1);
    @(posedge clk);
  endtask

  task automatic watch(input int d, input int n, input bit keep, input logic [DB-1:0] nxt);
    ld_q.delete(); sh_q.delete(); dn_q.delete();
    rdy_first = 0; ser_v = '1; par1 = '0; par_mid = '0;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      if (k == 1) begin vld[d] = keep; dat[d] = nxt; end
      #1;
      if (ld[d]) ld_q.push_back(k);
      if (sh[d]) sh_q.push_back(k);
      if (dn[d]) dn_q.push_back(k);
      if (rdy[d] && rdy_first == 0) rdy_first = k;
      if (k == 1)  par1 = par[d];
      if (k == 20) par_mid = par[d];
      if (k >= 2 && (k - 2) % cpb[d] == 0 && (k - 2) / cpb[d] < FB)
        ser_v[(k - 2) / cpb[d]] = bsr[d][0];
    end
  endtask

  initial begin
    n_rst = 1'b1;
    #1 n_rst = 1'b0;
    // reset with requests pending
    @(negedge clk); vld = 2'b11; dat[0] = 8'h12; dat[1] = 8'h34;
    repeat (3) @(negedge clk);
    #2;
    chk("rst ready", rdy, 2'b11);
    chk("rst busy", busy, 2'b00);
    chk("rst enables", {ld, sh, dn}, 6'b0);
    chk("rst par", par[0], ONES);
    @(negedge clk); vld = 2'b00; n_rst = 1'b1;
    repeat (2) @(negedge clk);

    // single frame 0xA5
    accept(0, 8'hA5);
    watch(0, RDY4, 0, 8'h00);
    chk("A5 par", par1, F_A5);
    chk("A5 load cnt", ld_q.size(), 1);
    chk("A5 load cyc", ld_q[0], 1);
    chk("A5 shift cnt", sh_q.size(), FB);
    chk("A5 first shift", sh_q[0], 5);
    chk("A5 last shift", sh_q[$], LAST4);
    chk("A5 done cyc", dn_q[0], DONE4);
    chk("A5 ready cyc", rdy_first, RDY4);
    chk("A5 serial", ser_v, F_A5);
    repeat (3) @(negedge clk);

    // busy rejection: 0xFF held from cycle 1 onward
    accept(0, 8'h3C);
    watch(0, NEXTLD + 1, 1, 8'hFF);
    chk("3C par", par1, F_3C);
    chk("3C par mid", par_mid, F_3C);
    chk("3C ready cyc", rdy_first, RDY4);
    chk("3C load cnt", ld_q.size(), 2);
    chk("FF load cyc", ld_q[$], NEXTLD);
    chk("FF par", par[0], F_FF);
    @(negedge clk); vld[0] = 1'b0;
    repeat (60) @(negedge clk);

    // CLKS_PER_BIT = 1
    accept(1, 8'h00);
    watch(1, DONE1 + 2, 0, 8'h00);
    chk("cpb1 shift cnt", sh_q.size(), FB);
    chk("cpb1 first shift", sh_q[0], 2);
    chk("cpb1 last shift", sh_q[$], LAST1);
    chk("cpb1 done cyc", dn_q[0], DONE1);
    repeat (3) @(negedge clk);

    // reset in cycle 20 of a frame, then 0x81 right after release
    accept(0, 8'hA5);
    watch(0, 19, 0, 8'h00);
    @(negedge clk); n_rst = 1'b0; vld[0] = 1'b1; dat[0] = 8'h81;
    #1;
    chk("midrst busy", busy[0], 0);
    chk("midrst par", par[0], ONES);
    chk("midrst done", dn[0], 0);
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    @(posedge clk);
    watch(0, RDY4, 0, 8'h00);
    chk("81 par", par1, F_81);
    chk("81 shift cnt", sh_q.size(), FB);
    chk("81 done cnt", dn_q.size(), 1);
    chk("81 done cyc", dn_q[0], DONE4);
    chk("81 serial", ser_v, F_81);
    repeat (3) @(negedge clk);

`ifdef PTS_TX_PARITY_EN
    accept(0, 8'h07);
    watch(0, 47, 0, 8'h00);
    chk("07 par", par1, 11'b1_1_00000111_0);
    chk("07 shift cnt", sh_q.size(), 11);
    chk("07 done cyc", dn_q[0], 46);
    repeat (3) @(negedge clk);
`endif

    // random traffic with occasional resets
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      n_rst = ($urandom_range(0, 599) != 0);
      for (int d = 0; d < 2; d++) begin
        vld[d] = ($urandom_range(0, 3) != 0);
        dat[d] = DB'($urandom);
      end
    end
    @(negedge clk); n_rst = 1'b1; vld = 2'b00;
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pts_tx_ctrl.md
Name: pts_tx_ctrl

Overview:
- Transmit sequencer for the team's parameterised parallel-to-serial shift register, configured LSB-first with idle-high fill.
- Accepts one data word per valid/ready handshake and frames it UART-style as start bit, data, optional parity bit, then stop bit.
- Drives the register's load and shift enables at a programmable bit period.
- Sits between the packet/FIFO logic and the serial line driver.

Parameters:
- DATA_BITS, 8, payload width per frame (>=1).
- CLKS_PER_BIT, 4, clk cycles per serial bit (>=1).
- FRAME_BITS, derived localparam = DATA_BITS+2, or DATA_BITS+3 with parity; not overridable.

Ports:
- clk  in  1  system clock, rising edge.
- n_rst  in  1  asynchronous active-low reset.
- tx_data  in  DATA_BITS  payload word, sampled on the accept edge.
- tx_valid  in  1  requester has a word.
- tx_ready  out  1  controller can accept; high only in IDLE.
- sr_parallel_out  out  FRAME_BITS  frame image for the shift register parallel input.
- sr_load_enable  out  1  one-cycle load pulse to the shift register.
- sr_shift_enable  out  1  one-cycle shift pulse, once per bit period.
- tx_busy  out  1  high in every state except IDLE.
- frame_done  out  1  one-cycle pulse after the stop bit completes.

Behaviour:
- Reset: reset n_rst, asynchronous, active-low; clock clk. On reset: state=IDLE, tx_ready=1, tx_busy=0, sr_load_enable=0, sr_shift_enable=0, frame_done=0, sr_parallel_out all ones, bit timer=0, bit counter=0.
- States: IDLE, LOAD, SHIFT, DONE. Enables and flags are Moore decodes of state and counters.
- Accept: a rising edge with tx_valid && tx_ready captures tx_data into the frame register, then IDLE->LOAD.
- Frame image: {1'b1 stop, data, 1'b0 start}, start bit at index 0.
- Timing: cycle k means the k-th clk period after the accept edge.
  - Cycle 1 (LOAD): sr_load_enable=1; next state SHIFT.
  - SHIFT: the bit timer counts 1..CLKS_PER_BIT and wraps to 1. sr_shift_enable=1 in every cycle where timer==CLKS_PER_BIT, i.e. cycles 1+n*CLKS_PER_BIT for n=1..FRAME_BITS. Each shift pulse increments the bit counter.
  - After the FRAME_BITS-th shift pulse: next state DONE. frame_done=1 for exactly one cycle (cycle 2+FRAME_BITS*CLKS_PER_BIT), then IDLE.
- Each serial bit is held exactly CLKS_PER_BIT cycles. The line returns high via the register's one-fill.
- CLKS_PER_BIT=1: a shift pulse occurs every SHIFT cycle. The timer width is $clog2(CLKS_PER_BIT+1) and must not overflow.
- tx_valid while not IDLE: ignored, no capture. The requester holds tx_data/tx_valid until tx_ready.
- tx_data changing mid-frame: no effect, because the word is captured at accept.
- Back-to-back: a new accept is possible at the earliest one cycle after DONE (IDLE). Minimum frame-to-frame period is FRAME_BITS*CLKS_PER_BIT+3 cycles.
- sr_load_enable and sr_shift_enable are never high in the same cycle.
- Reset mid-frame: immediate return to reset values. The partial frame is discarded and frame_done does not pulse.

Optional Feature:
- Macro: PTS_TX_PARITY_EN.
- Defined: FRAME_BITS=DATA_BITS+3; frame = {1'b1, ^data (even parity), data, 1'b0}.
- Undefined: no parity bit; FRAME_BITS=DATA_BITS+2.

Decomposition:
- Package pts_tx_pkg holds:
  - typedef enum logic [1:0] tx_state_t {IDLE, LOAD, SHIFT, DONE};
  - localparam PARITY_BITS (1 or 0 under PTS_TX_PARITY_EN).
  - function frame_bits(data_bits), returning data_bits+2+PARITY_BITS.
- Sub-module bit_period_timer(clk, n_rst, clear, enable, rollover_val, rollover_flag) implements the 1..CLKS_PER_BIT wrap counter. The controller instantiates it twice: once as the bit timer, once as the bit counter with rollover_val=FRAME_BITS.

Test Plan:
- Reset check: assert n_rst=0 with tx_valid=1 -> tx_ready=1, tx_busy=0, both enables 0, sr_parallel_out=10'h3FF; no accept while in reset.
- Single frame: DATA_BITS=8, CLKS_PER_BIT=4, send 0xA5.
  - Required: sr_parallel_out=10'b1_10100101_0 and load pulse in cycle 1.
  - Shift pulses in cycles 5,9,...,41 (10 pulses); frame_done in cycle 42; tx_ready=1 in cycle 43.
  - Serial output of the attached shift register: 0,1,0,1,0,0,1,0,1,1, each for 4 cycles.
- Busy rejection: send 0x3C, then hold tx_valid with 0xFF during SHIFT -> tx_ready=0 and the frame still carries 0x3C. 0xFF is accepted in cycle 43 and its load pulse appears in cycle 44.
- CLKS_PER_BIT=1, send 0x00 -> shift pulses in cycles 2..11 consecutively; frame_done in cycle 12.
- Reset mid-frame: reset in cycle 20 of the 0xA5 frame -> all outputs return to reset values, no frame_done. A new 0x81 is accepted right after reset release and runs a full, correctly timed frame.
- Parity: with PTS_TX_PARITY_EN and CLKS_PER_BIT=4, send 0x07 -> sr_parallel_out=11'b1_1_00000111_0, 11 shift pulses, frame_done in cycle 46.
